decade_borrow_tracker: RTL



---
 rtl/decade_borrow_tracker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/decade_borrow_tracker.sv
// Resynchronises a rippling decade count, tracks units/tens digits, borrows and a 00 alarm.
// Optional SEG7_EN adds registered 7-segment (gfedcba) encodings of both digits.
module decade_borrow_tracker #(
   parameter int unsigned WIDTH     = 5,
   parameter logic [3:0]  TENS_INIT = 4'd9
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] count_in,
   input  logic             alarm_ack,
   output logic [3:0]       units,
   output logic [3:0]       tens,
   output logic             borrow,
   output logic             tens_wrap,
   output logic             alarm,
`ifdef SEG7_EN
   output logic [6:0]       seg_units,
   output logic [6:0]       seg_tens,
`endif
   output logic             err
);

   typedef enum logic [1:0] {StIdle, StRun, StAlarm} state_e;

   state_e     state_q, state_d;
   logic [3:0] sync1_q, sync2_q, s3_q;
   logic       hi1_q, hi2_q, hi3_q;
   logic [1:0] fill_q;
   logic       seen_q;
   logic [3:0] units_q, units_d, tens_q, tens_d;
   logic       borrow_q, borrow_d, wrap_q, wrap_d, err_q, err_d, alarm_q;
   logic       stable, valid, accept, zero_entry;

   always_comb begin
      // Stability is only meaningful once the pipeline holds post-reset samples.
      stable     = (fill_q == 2'd3) && (sync2_q == s3_q) && (hi2_q == hi3_q);
      valid      = !hi3_q && (s3_q <= 4'd9);
      accept     = stable && valid && (!seen_q || (s3_q != units_q));
      units_d    = units_q;
      tens_d     = tens_q;
      borrow_d   = 1'b0;
      wrap_d     = 1'b0;
      err_d      = err_q | (stable & ~valid);
      if (accept) begin
         units_d = s3_q;
         if ((units_q == 4'd0) && (s3_q == 4'd9)) begin
            borrow_d = 1'b1;
            if (tens_q == 4'd0) begin
               tens_d = TENS_INIT;
               wrap_d = 1'b1;
            end else begin
               tens_d = tens_q - 4'd1;
            end
         end
      end
      zero_entry = accept && (units_d == 4'd0) && (tens_d == 4'd0);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (zero_entry) state_d = StAlarm;
         StAlarm: if (!zero_entry && alarm_ack) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         sync1_q  <= 4'd0;
         sync2_q  <= 4'd0;
         s3_q     <= 4'd0;
         hi1_q    <= 1'b0;
         hi2_q    <= 1'b0;
         hi3_q    <= 1'b0;
         fill_q   <= 2'd0;
         seen_q   <= 1'b0;
         units_q  <= 4'd0;
         tens_q   <= TENS_INIT;
         borrow_q <= 1'b0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
         alarm_q  <= 1'b0;
         state_q  <= StIdle;
      end else begin
         sync1_q  <= count_in[3:0];
         sync2_q  <= sync1_q;
         s3_q     <= sync2_q;
         hi1_q    <= |count_in[WIDTH-1:4];
         hi2_q    <= hi1_q;
         hi3_q    <= hi2_q;
         if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
         if (accept) seen_q <= 1'b1;
         units_q  <= units_d;
         tens_q   <= tens_d;
         borrow_q <= borrow_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
         alarm_q  <= (state_d == StAlarm);
         state_q  <= state_d;
      end
   end

   assign units     = units_q;
   assign tens      = tens_q;
   assign borrow    = borrow_q;
   assign tens_wrap = wrap_q;
   assign alarm     = alarm_q;
   assign err       = err_q;

`ifdef SEG7_EN
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   logic [6:0] seg_units_q, seg_tens_q;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         seg_units_q <= seg7(4'd0);
         seg_tens_q  <= seg7(TENS_INIT);
      end else begin
         seg_units_q <= seg7(units_q);
         seg_tens_q  <= seg7(tens_q);
      end
   end

   assign seg_units = seg_units_q;
   assign seg_tens  = seg_tens_q;
`endif

endmodule
